fuel_pump_sequencer: RTL and testbench
======================================

FUEL_PUMP_SEQUENCER -- requirements
Module: fuel_pump_sequencer

Interface
REQ-001 Parameter ARM_CYCLES, default 8: consecutive cycles ignition, switch and pedal must be held together to arm.
REQ-002 Parameter PRIME_CYCLES, default 16: pump priming duration in cycles.
REQ-003 Parameter STALL_CYCLES, default 32: maximum cycles allowed in RUN without an engine_pulse.
REQ-004 Parameter CNT_W, default 16: width of the shared timer; each cycle parameter SHALL be >=1 and <2^CNT_W.
REQ-005 clock  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 ignition  input  1  ignition key on.
REQ-008 switch  input  1  hidden arming switch.
REQ-009 pedal  input  1  brake pedal pressed.
REQ-010 alarm_active  input  1  alarm system triggered; overrides all other inputs.
REQ-011 engine_pulse  input  1  one-cycle tach pulse, engine turning.
REQ-012 pump_on  output  1  fuel pump drive.
REQ-013 state  output  3  current state encoding, for status display.
REQ-014 stall  output  1  one-cycle pulse when RUN times out.

Function
REQ-015 States SHALL be IDLE=0, ARM=1, PRIME=2, RUN=3, LOCKOUT=4; codes 5-7 SHALL go to IDLE on the next cycle.
REQ-016 Priority each cycle SHALL be: alarm_active, then ignition low, then timer or pulse events.
REQ-017 In IDLE: alarm_active SHALL go to LOCKOUT; ignition&switch&pedal SHALL go to ARM with the timer loaded to ARM_CYCLES-1.
REQ-018 In ARM: if any of ignition, switch or pedal drops, the block SHALL go to IDLE.
REQ-019 In ARM: with all three held, the timer SHALL decrement; at 0, the block SHALL go to PRIME with the timer loaded to PRIME_CYCLES-1.
REQ-020 ARM_CYCLES=1 SHALL reach PRIME exactly one cycle after entering ARM.
REQ-021 In PRIME: engine_pulse SHALL go to RUN immediately; otherwise timer expiry at 0 SHALL go to RUN; switch and pedal SHALL be ignored.
REQ-022 On every entry to RUN the timer SHALL load STALL_CYCLES-1.
REQ-023 In RUN: engine_pulse SHALL reload the timer to STALL_CYCLES-1.
REQ-024 In RUN: timer at 0 without engine_pulse SHALL go to IDLE and assert stall for exactly that one transition cycle.
REQ-025 In RUN: engine_pulse and timer 0 in the same cycle SHALL reload the timer; no stall.
REQ-026 In ARM, PRIME and RUN: ignition low SHALL go to IDLE; alarm_active SHALL go to LOCKOUT.
REQ-027 In LOCKOUT: the block SHALL go to IDLE only when alarm_active and ignition are both low in the same cycle.
REQ-028 pump_on and state SHALL be registered.
REQ-029 pump_on SHALL be 1 exactly in the cycles when state is PRIME or RUN; no combinational input-to-output path.
REQ-030 The timer SHALL never wrap: it SHALL hold at 0 until reloaded.

Reset
REQ-031 While reset is low: state=IDLE, pump_on=0, stall=0, timer=0, taking effect immediately regardless of clock.
REQ-032 Reset mid-PRIME or mid-RUN SHALL drop pump_on asynchronously.
REQ-033 After release, re-arming SHALL require a fresh full ARM_CYCLES hold.

Structure
REQ-034 State encoding constants and the state typedef SHALL live in a shared package fuel_pkg for the alarm top and display logic.
REQ-035 The timer SHALL be one sub-module, cycle_timer (load, load_value, decrement, zero flag), reusable by other alarm blocks.
REQ-036 The FSM SHALL be a single registered state with separate next-state logic.

Verification
REQ-037 Defaults; hold ignition/switch/pedal 8 cycles -> state 1 for 8 cycles, then 2 with pump_on=1 for 16 cycles, then 3.
REQ-038 Arm, drop pedal on ARM cycle 5 -> state 0 next cycle, pump_on never asserted.
REQ-039 In RUN, pulse every 20 cycles for 200 cycles -> pump_on held 1, stall never asserted; stop pulses -> stall pulses once after 32 cycles, state 0, pump_on 0.
REQ-040 In RUN, assert alarm_active and drop ignition in the same cycle -> state 4, pump_on 0; release alarm with ignition high -> stays 4; drop ignition -> state 0.
REQ-041 Engine_pulse on PRIME cycle 3 -> state 3 next cycle, stall timer at 31.
REQ-042 Assert reset low mid-RUN between clock edges -> pump_on 0 before next edge; after release, a 7-cycle hold does not reach PRIME.

Source files
------------

// File: rtl/fuel_pkg.sv
// Purpose : shared state encoding for the fuel pump sequencer and its status display.
// Latency : n/a (types and constants only).
// Backpres: n/a.
package fuel_pkg;

    localparam int STATE_W = 3;

    // Codes are visible on the status display, so they are fixed explicitly.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_PRIME   = 3'd2,
        ST_RUN     = 3'd3,
        ST_LOCKOUT = 3'd4
    } fuel_state_e;

    // The pump is driven only while priming or running.
    function automatic logic pump_for(input fuel_state_e s);
        return (s == ST_PRIME) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Purpose : loadable down-counter with zero flag, saturating at 0 (never wraps).
// Latency : load/decrement take effect on the next rising edge; zero_o is registered-state derived.
// Backpres: none; load has priority over decrement.
// Ports   : clk_i, rst_ni (async active-low), load_i + load_value_i, dec_i, zero_o.
module cycle_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_value_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_value_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fuel_pump_sequencer.sv
// Purpose : anti-theft fuel pump sequencer: arm on a held ignition+switch+pedal combo, prime, run, stall-detect, alarm lockout.
// Latency : all outputs registered; state/pump_on/stall change one edge after the inputs that cause them.
// Backpres: none; inputs are sampled every cycle.
// Ports   : clk_i, rst_ni (async active-low), ignition_i, switch_i, pedal_i, alarm_active_i,
//           engine_pulse_i, pump_on_o, state_o[2:0], stall_o.
module fuel_pump_sequencer
    import fuel_pkg::*;
#(
    parameter int unsigned ARM_CYCLES   = 8,
    parameter int unsigned PRIME_CYCLES = 16,
    parameter int unsigned STALL_CYCLES = 32,
    parameter int          CNT_W        = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               ignition_i,
    input  logic               switch_i,
    input  logic               pedal_i,
    input  logic               alarm_active_i,
    input  logic               engine_pulse_i,
    output logic               pump_on_o,
    output logic [STATE_W-1:0] state_o,
    output logic               stall_o
);

    // Each phase counts down to 0 inclusive, so the load value is N-1 for an N-cycle phase.
    localparam logic [CNT_W-1:0] ARM_LOAD   = CNT_W'(ARM_CYCLES - 1);
    localparam logic [CNT_W-1:0] PRIME_LOAD = CNT_W'(PRIME_CYCLES - 1);
    localparam logic [CNT_W-1:0] STALL_LOAD = CNT_W'(STALL_CYCLES - 1);

    fuel_state_e      state_q, state_d;
    logic             pump_on_q, pump_on_d;
    logic             stall_q, stall_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_value;
    logic             tmr_dec;
    logic             tmr_zero;

    cycle_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .load_i       (tmr_load),
        .load_value_i (tmr_load_value),
        .dec_i        (tmr_dec),
        .zero_o       (tmr_zero)
    );

    // Next-state logic. Within every active state the alarm is checked first,
    // then ignition, then timer/pulse events.
    always_comb begin
        state_d        = state_q;
        tmr_load       = 1'b0;
        tmr_load_value = '0;
        tmr_dec        = 1'b0;
        stall_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (alarm_active_i) begin
                    state_d = ST_LOCKOUT;
                end else if (ignition_i && switch_i && pedal_i) begin
                    state_d        = ST_ARM;
                    tmr_load       = 1'b1;
                    tmr_load_value = ARM_LOAD;
                end
            end

            ST_ARM: begin
                if (alarm_active_i) begin
                    state_d = ST_LOCKOUT;
                end else if (!ignition_i || !switch_i || !pedal_i) begin
                    state_d = ST_IDLE;
                end else if (tmr_zero) begin
                    state_d        = ST_PRIME;
                    tmr_load       = 1'b1;
                    tmr_load_value = PRIME_LOAD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            // Switch and pedal are deliberately not looked at once priming has begun.
            ST_PRIME: begin
                if (alarm_active_i) begin
                    state_d = ST_LOCKOUT;
                end else if (!ignition_i) begin
                    state_d = ST_IDLE;
                end else if (engine_pulse_i || tmr_zero) begin
                    state_d        = ST_RUN;
                    tmr_load       = 1'b1;
                    tmr_load_value = STALL_LOAD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            // A pulse wins over a simultaneous expiry: the engine is still turning.
            ST_RUN: begin
                if (alarm_active_i) begin
                    state_d = ST_LOCKOUT;
                end else if (!ignition_i) begin
                    state_d = ST_IDLE;
                end else if (engine_pulse_i) begin
                    tmr_load       = 1'b1;
                    tmr_load_value = STALL_LOAD;
                end else if (tmr_zero) begin
                    state_d = ST_IDLE;
                    stall_d = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            // Leaving lockout needs the key off as well, so the alarm cannot be
            // cleared into a live ignition.
            ST_LOCKOUT: begin
                if (!alarm_active_i && !ignition_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // pump_on is derived from the next state so it is registered in lockstep with state.
    assign pump_on_d = pump_for(state_d);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            pump_on_q <= 1'b0;
            stall_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pump_on_q <= pump_on_d;
            stall_q   <= stall_d;
        end
    end

    // stall is high in the first IDLE cycle after a RUN timeout, i.e. the cycle
    // in which the timeout transition becomes visible.
    assign pump_on_o = pump_on_q;
    assign state_o   = state_q;
    assign stall_o   = stall_q;

endmodule

// File: tb/tb_fuel_pump_sequencer.sv
module tb_fuel_pump_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ign, sw, pd, alarm, pulse;
    logic       pump, stall;
    logic [2:0] state;

    // Second instance with minimum-length phases for boundary timing.
    logic       ign1, sw1, pd1;
    logic       pump1, stall1;
    logic [2:0] state1;

    int tests = 0;
    int fails = 0;
    int n;
    int bad;
    int seen;

    always #5 clk = ~clk;

    fuel_pump_sequencer dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .ignition_i     (ign),
        .switch_i       (sw),
        .pedal_i        (pd),
        .alarm_active_i (alarm),
        .engine_pulse_i (pulse),
        .pump_on_o      (pump),
        .state_o        (state),
        .stall_o        (stall)
    );

    fuel_pump_sequencer #(
        .ARM_CYCLES   (1),
        .PRIME_CYCLES (2),
        .STALL_CYCLES (3),
        .CNT_W        (16)
    ) dut1 (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .ignition_i     (ign1),
        .switch_i       (sw1),
        .pedal_i        (pd1),
        .alarm_active_i (1'b0),
        .engine_pulse_i (1'b0),
        .pump_on_o      (pump1),
        .state_o        (state1),
        .stall_o        (stall1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; returns at the falling edge where outputs are stable.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int k;
        k = 0;
        while (state !== s && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(state), 32'(s));
    endtask

    initial begin
        rst_n = 1'b0;
        ign = 1'b0; sw = 1'b0; pd = 1'b0; alarm = 1'b0; pulse = 1'b0;
        ign1 = 1'b0; sw1 = 1'b0; pd1 = 1'b0;

        // Reset state
        #12;
        chk("rst_state", 32'(state), 0);
        chk("rst_pump", 32'(pump), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_state1", 32'(state1), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Minimum phase lengths: ARM 1, PRIME 2, RUN stall after 3
        ign1 = 1'b1; sw1 = 1'b1; pd1 = 1'b1;
        tick(); chk("a1_arm", 32'(state1), 1);
        tick(); chk("a1_prime", 32'(state1), 2);
        chk("a1_pump", 32'(pump1), 1);
        tick(); chk("a1_prime2", 32'(state1), 2);
        tick(); chk("a1_run", 32'(state1), 3);
        tick(); tick(); chk("a1_run3", 32'(state1), 3);
        tick(); chk("a1_idle", 32'(state1), 0);
        chk("a1_stall", 32'(stall1), 1);
        ign1 = 1'b0; sw1 = 1'b0; pd1 = 1'b0;
        tick(); chk("a1_stall_once", 32'(stall1), 0);

        // Full arm, prime, run with defaults
        ign = 1'b1; sw = 1'b1; pd = 1'b1;
        tick();
        n = 0;
        while (state === 3'd1 && n < 100) begin n++; tick(); end
        chk("arm_len", 32'(n), 8);
        chk("prime_enter", 32'(state), 2);
        n = 0; bad = 0;
        while (state === 3'd2 && n < 100) begin
            if (pump !== 1'b1) bad++;
            n++; tick();
        end
        chk("prime_len", 32'(n), 16);
        chk("prime_pump_bad", 32'(bad), 0);
        chk("run_enter", 32'(state), 3);
        chk("run_pump", 32'(pump), 1);

        // Pulses every 20 cycles keep it running
        bad = 0; seen = 0;
        for (int c = 0; c < 200; c++) begin
            pulse = (c % 20 == 19);
            tick();
            pulse = 1'b0;
            if (pump !== 1'b1 || state !== 3'd3) bad++;
            if (stall !== 1'b0) seen++;
        end
        chk("run_hold_bad", 32'(bad), 0);
        chk("run_no_stall", 32'(seen), 0);
        n = 0;
        while (stall !== 1'b1 && n < 100) begin tick(); n++; end
        chk("stall_delay", 32'(n), 32);
        chk("stall_state", 32'(state), 0);
        chk("stall_pump", 32'(pump), 0);
        ign = 1'b0; sw = 1'b0; pd = 1'b0;
        tick();
        chk("stall_once", 32'(stall), 0);

        // Pedal dropped on ARM cycle 5
        ign = 1'b1; sw = 1'b1; pd = 1'b1;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (pump !== 1'b0) seen++;
        end
        chk("arm5_state", 32'(state), 1);
        pd = 1'b0;
        tick();
        if (pump !== 1'b0) seen++;
        chk("pedal_drop", 32'(state), 0);
        chk("pedal_no_pump", 32'(seen), 0);
        ign = 1'b0; sw = 1'b0;
        tick();

        // Engine pulse on PRIME cycle 3; switch/pedal ignored in PRIME
        ign = 1'b1; sw = 1'b1; pd = 1'b1;
        wait_state(3'd2, 20, "to_prime");
        sw = 1'b0; pd = 1'b0;
        tick(); tick();
        chk("prime_c3", 32'(state), 2);
        pulse = 1'b1;
        tick();
        pulse = 1'b0;
        chk("pulse_run", 32'(state), 3);
        n = 0;
        while (state === 3'd3 && n < 100) begin n++; tick(); end
        chk("run_len_after_pulse", 32'(n), 32);
        chk("pulse_stall", 32'(stall), 1);
        ign = 1'b0;
        tick();

        // Alarm and ignition drop together in RUN
        ign = 1'b1; sw = 1'b1; pd = 1'b1;
        wait_state(3'd3, 40, "to_run");
        alarm = 1'b1; ign = 1'b0;
        tick();
        chk("lock_enter", 32'(state), 4);
        chk("lock_pump", 32'(pump), 0);
        alarm = 1'b0; ign = 1'b1;
        tick(); tick();
        chk("lock_hold_ign", 32'(state), 4);
        ign = 1'b0;
        tick();
        chk("lock_exit", 32'(state), 0);
        sw = 1'b0; pd = 1'b0;
        alarm = 1'b1;
        tick();
        chk("idle_alarm", 32'(state), 4);
        alarm = 1'b0;
        tick();
        chk("idle_alarm_exit", 32'(state), 0);

        // Asynchronous reset mid-RUN, then a short re-arm attempt
        ign = 1'b1; sw = 1'b1; pd = 1'b1;
        wait_state(3'd3, 40, "to_run2");
        #2 rst_n = 1'b0;
        #1;
        chk("async_pump", 32'(pump), 0);
        chk("async_state", 32'(state), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 7; k++) begin
            tick();
            if (state === 3'd2) seen++;
        end
        chk("rearm7_state", 32'(state), 1);
        ign = 1'b0; sw = 1'b0; pd = 1'b0;
        tick();
        chk("rearm7_idle", 32'(state), 0);
        chk("rearm7_no_prime", 32'(seen), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
